// File: rtl/uart_pkg.sv
// Shared UART link definitions: default baud divider, 8N1 frame constants and
// state encodings used by both the word transmitter and the matching receiver.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 868;   // 100 MHz / 115200 baud

    localparam int   DATA_BITS      = 8;
    localparam int   BYTES_PER_WORD = 4;
    localparam logic UART_IDLE      = 1'b1;
    localparam logic START_LVL      = 1'b0;

    typedef enum logic [1:0] {
        B_IDLE  = 2'd0,
        B_START = 2'd1,
        B_DATA  = 2'd2,
        B_STOP  = 2'd3
    } bit_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_SEND = 2'd1,
        W_DONE = 2'd2
    } word_state_t;

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 single-byte serialiser, LSB first; tx is a flop.
// Latency: start bit on tx the cycle after byte_start; 10*CLKS_PER_BIT cycles per frame.
// Backpressure: none; byte_start is honoured in idle or on the byte_done cycle only.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_start,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       byte_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    bit_state_t    state, state_n;
    logic [CW-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          tx_n;
    logic          baud_last;

    assign baud_last = (baud_cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= B_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= UART_IDLE;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            shreg    <= shreg_n;
            tx       <= tx_n;
        end
    end

    // tx_n is the level for the next cycle, so every change lands on a bit boundary.
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_idx_n  = bit_idx;
        shreg_n    = shreg;
        tx_n       = tx;
        byte_done  = 1'b0;
        case (state)
            B_IDLE: begin
                tx_n = UART_IDLE;
                if (byte_start) begin
                    shreg_n    = byte_in;
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    tx_n       = START_LVL;
                    state_n    = B_START;
                end
            end
            B_START: begin
                if (baud_last) begin
                    baud_cnt_n = '0;
                    tx_n       = shreg[0];
                    state_n    = B_DATA;
                end else begin
                    baud_cnt_n = baud_cnt + CW'(1);
                end
            end
            B_DATA: begin
                if (baud_last) begin
                    baud_cnt_n = '0;
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        bit_idx_n = '0;
                        tx_n      = UART_IDLE;
                        state_n   = B_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        shreg_n   = {1'b0, shreg[7:1]};
                        tx_n      = shreg[1];
                    end
                end else begin
                    baud_cnt_n = baud_cnt + CW'(1);
                end
            end
            B_STOP: begin
                if (baud_last) begin
                    byte_done  = 1'b1;
                    baud_cnt_n = '0;
                    // Back-to-back restart keeps the next start bit gap-free.
                    if (byte_start) begin
                        shreg_n = byte_in;
                        tx_n    = START_LVL;
                        state_n = B_START;
                    end else begin
                        tx_n    = UART_IDLE;
                        state_n = B_IDLE;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + CW'(1);
                end
            end
            default: begin
                tx_n    = UART_IDLE;
                state_n = B_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/uart_word_tx.sv
// 32-bit word transmitter: four back-to-back 8N1 frames, little-endian byte order.
// Latency: first start bit at T+1, data_end pulse at T+1+40*CLKS_PER_BIT.
// Backpressure: busy from acceptance through data_end; send_start/data_in ignored while busy.
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        send_start,
    input  logic [31:0] data_in,
    output logic        tx,
    output logic        data_end,
    output logic        busy
);

    word_state_t state, state_n;
    logic [31:0] shreg, shreg_n;
    logic [1:0]  byte_idx, byte_idx_n;
    logic        byte_start;
    logic [7:0]  byte_in;
    logic        byte_done;

    uart_byte_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte_tx (
        .clk        (clk),
        .reset      (reset),
        .byte_start (byte_start),
        .byte_in    (byte_in),
        .tx         (tx),
        .byte_done  (byte_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= W_IDLE;
            shreg    <= '0;
            byte_idx <= '0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            byte_idx <= byte_idx_n;
        end
    end

    // Busy covers the acceptance cycle itself so the bridge sees it immediately.
    assign busy = (state != W_IDLE) || (send_start && !reset);

    // shreg[7:0] is the byte on the wire, so shreg[15:8] is the one to chain next.
    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        byte_idx_n = byte_idx;
        byte_start = 1'b0;
        byte_in    = shreg[15:8];
        data_end   = 1'b0;
        case (state)
            W_IDLE: begin
                byte_in = data_in[7:0];
                if (send_start) begin
                    byte_start = 1'b1;
                    shreg_n    = data_in;
                    byte_idx_n = '0;
                    state_n    = W_SEND;
                end
            end
            W_SEND: begin
                if (byte_done) begin
                    if (byte_idx != 2'(BYTES_PER_WORD - 1)) begin
                        byte_start = 1'b1;
                        shreg_n    = {8'h00, shreg[31:8]};
                        byte_idx_n = byte_idx + 2'd1;
                    end else begin
                        state_n = W_DONE;
                    end
                end
            end
            W_DONE: begin
                data_end = 1'b1;
                state_n  = W_IDLE;
            end
            default: state_n = W_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed and loopback bench for uart_word_tx at CLKS_PER_BIT=4; a UART decoder
// samples tx mid-bit and the expected bytes/cycles are hand-derived constants.
module tb_uart_word_tx;

    localparam int C = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        send_start;
    logic [31:0] data_in;
    logic        tx;
    logic        data_end;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_end    = 0;
    int frame_err = 0;
    logic [7:0] rx_q[$];
    int         start_q[$];

    uart_word_tx #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .reset      (reset),
        .send_start (send_start),
        .data_in    (data_in),
        .tx         (tx),
        .data_end   (data_end),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (data_end === 1'b1) n_end <= n_end + 1;

    // Receiver model: detect start, sample each bit mid-period, require a high stop bit.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && tx === 1'b0) begin
                int s;
                logic [7:0] b;
                s = cyc;
                b = '0;
                repeat (C/2) @(negedge clk);
                if (tx === 1'b0) begin
                    for (int k = 0; k < 8; k++) begin
                        repeat (C) @(negedge clk);
                        b[k] = tx;
                    end
                    repeat (C) @(negedge clk);
                    if (tx === 1'b1) begin
                        rx_q.push_back(b);
                        start_q.push_back(s);
                    end else begin
                        frame_err++;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rx();
        rx_q.delete();
        start_q.delete();
    endtask

    task automatic send_pulse(input logic [31:0] w, output int t);
        tick();
        data_in    = w;
        send_start = 1'b1;
        t          = cyc;
        @(negedge clk);
        check("busy_at_T", {31'd0, busy}, 32'd1);
        tick();
        send_start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output int e, output bit busy_ok);
        e       = -1;
        busy_ok = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (data_end === 1'b1) begin
                e = cyc;
                break;
            end
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] w);
        logic [31:0] got;
        got = '0;
        check({tag, "_nbytes"}, (rx_q.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
        if (rx_q.size() >= 4) begin
            for (int k = 0; k < 4; k++) got[k*8 +: 8] = rx_q.pop_front();
            void'(start_q.pop_front());
            void'(start_q.pop_front());
            void'(start_q.pop_front());
            void'(start_q.pop_front());
        end
        check(tag, got, w);
    endtask

    initial begin
        int t, e, e1, e2, n0;
        bit ok;
        logic [31:0] w;

        reset = 1'b1;
        send_start = 1'b0;
        data_in = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_data_end", {31'd0, data_end}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        tick();
        reset = 1'b0;
        repeat (3) tick();

        // Single word, byte order and exact latency
        clear_rx();
        send_pulse(32'hDEADBEEF, t);
        wait_end(300, e, ok);
        check("beef_end_cycle", e, t + 161);
        check("beef_busy_held", {31'd0, ok}, 32'd1);
        check("beef_first_start", (start_q.size() > 0) ? start_q[0] : -1, t + 1);
        @(negedge clk);
        check("beef_end_single", {31'd0, data_end}, 32'd0);
        check("beef_busy_after", {31'd0, busy}, 32'd0);
        check_word("beef_word", 32'hDEADBEEF);

        // Held send_start: exactly one copy of each word, 2-cycle high gap
        repeat (5) tick();
        clear_rx();
        tick();
        data_in = 32'h00000001;
        send_start = 1'b1;
        t = cyc;
        wait_end(300, e1, ok);
        check("held_end1", e1, t + 161);
        data_in = 32'h12345678;
        wait_end(300, e2, ok);
        send_start = 1'b0;
        check("held_end2", e2, e1 + 162);
        repeat (20) tick();
        check("held_nbytes", rx_q.size(), 8);
        check("held_gap", (start_q.size() > 4) ? start_q[4] : -1, e1 + 2);
        check_word("held_word1", 32'h00000001);
        check_word("held_word2", 32'h12345678);

        // data_in change and extra send_start pulses while busy
        clear_rx();
        n0 = n_end;
        send_pulse(32'hA5A5A5A5, t);
        while (cyc < t + 20) tick();
        data_in = 32'hFFFFFFFF;
        while (cyc < t + 50) tick();
        send_start = 1'b1;
        tick();
        send_start = 1'b0;
        while (cyc < t + 100) tick();
        send_start = 1'b1;
        tick();
        send_start = 1'b0;
        wait_end(300, e, ok);
        check("busy_ign_end", e, t + 161);
        check("busy_ign_busy", {31'd0, ok}, 32'd1);
        repeat (60) tick();
        check("busy_ign_nend", n_end - n0, 1);
        check("busy_ign_nbytes", rx_q.size(), 4);
        check_word("busy_ign_word", 32'hA5A5A5A5);

        // Reset mid-frame
        clear_rx();
        n0 = n_end;
        send_pulse(32'hCAFEF00D, t);
        while (cyc < t + 70) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_tx", {31'd0, tx}, 32'd1);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        repeat (200) tick();
        check("rst_mid_no_end", n_end - n0, 0);
        clear_rx();
        send_pulse(32'h000000FF, t);
        wait_end(300, e, ok);
        check("post_rst_end", e, t + 161);
        check_word("post_rst_word", 32'h000000FF);

        // Random loopback with random idle gaps
        for (int i = 0; i < 100; i++) begin
            w = $urandom;
            send_pulse(w, t);
            wait_end(300, e, ok);
            check("loop_end", e, t + 161);
            check_word("loop_word", w);
            repeat ($urandom_range(0, 10)) tick();
        end
        check("frame_errors", frame_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
- 32-bit word transmitter on the memory bridge UART link. Sits directly downstream of the CPU memory bridge FSM.
- Takes a word (address or store data) plus a start request, and serialises it on tx as four back-to-back 8N1 byte frames.
- Pulses data_end once the last stop bit has finished, so the bridge FSM can advance.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200 baud); legal range >= 2.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- send_start  input  1  transfer request; level, may be held high across multiple cycles
- data_in  input  32  word to send; sampled only on the acceptance cycle
- tx  output  1  UART serial line; idles high
- data_end  output  1  one-cycle pulse, word fully transmitted
- busy  output  1  high from the acceptance cycle through the data_end cycle

Behaviour:
- Reset values: tx=1, data_end=0, busy=0, state=IDLE, all counters=0, shift register=0. Reset mid-frame aborts the frame and drives tx=1 on the next cycle; no data_end is produced.
- States: IDLE, START_BIT, DATA_BITS, STOP_BIT, DONE.
- IDLE:
  - tx=1.
  - If send_start=1 on cycle T: latch data_in into a 32-bit shift register, clear byte_idx, set busy, go to START_BIT.
  - T is the acceptance cycle.
- START_BIT: tx=0 for CLKS_PER_BIT cycles, first start-bit cycle T+1, then DATA_BITS.
- DATA_BITS:
  - tx = bit bit_idx of the current byte, LSB first; each bit held CLKS_PER_BIT cycles.
  - After bit 7, go to STOP_BIT.
- STOP_BIT:
  - tx=1 for CLKS_PER_BIT cycles.
  - If byte_idx<3: shift the register right 8, increment byte_idx, go to START_BIT. There is no inter-byte gap.
  - Otherwise go to DONE.
- Byte order: little-endian. Bytes are sent in the order data_in[7:0], [15:8], [23:16], [31:24].
- DONE:
  - data_end=1 and busy=1 for exactly one cycle, T+1+40*CLKS_PER_BIT.
  - tx=1. send_start is ignored in this cycle. Next state is IDLE unconditionally.
- send_start or data_in changes while busy: ignored; the latched word is sent unchanged.
- Held send_start:
  - A new word is accepted in the IDLE cycle right after DONE.
  - Minimum gap between consecutive words: 2 cycles with tx high (DONE + IDLE).
  - This lets the bridge hold start through address→data phases without double-sending the address.
- Counters:
  - baud counter width = clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1, wraps at bit boundary.
  - bit_idx is 3 bits, byte_idx is 2 bits; no overflow beyond terminal values.
- tx is driven from a flop; no combinational path from inputs to tx.

Decomposition:
- Shared package uart_pkg:
  - CLKS_PER_BIT default.
  - Frame constants (DATA_BITS=8, BYTES_PER_WORD=4, UART_IDLE=1'b1, START_LVL=1'b0).
  - State encoding localparams reused by the matching word receiver.
- One sub-module, uart_byte_tx: 8N1 single-byte serialiser (byte_start, byte_in, tx, byte_done).
  - uart_word_tx wraps it with a byte-sequencing FSM (IDLE, SEND_BYTE, DONE) and must preserve the same cycle timing above.
  - byte_done → next byte_start happens in the same cycle, so there is no gap.

Test Plan (CLKS_PER_BIT=4):
- Reset, then send_start pulse with data_in=32'hDEADBEEF at cycle T:
  - tx decodes as bytes EF, BE, AD, DE (LSB first, start 0 / stop 1, 4 cycles per bit).
  - data_end is a single pulse at T+161; busy is high T..T+161.
- send_start held high, data_in=32'h00000001, then switched to 32'h12345678 at the first data_end cycle:
  - exactly one frame of 01 00 00 00, then tx high for 2 cycles, then a frame of 78 56 34 12.
- data_in changed to 32'hFFFFFFFF at T+20 during a 32'hA5A5A5A5 transfer → transmitted bytes remain A5 A5 A5 A5.
- send_start pulses at T+50 and T+100 while busy → ignored; only one data_end; no extra start bits.
- reset asserted at T+70 mid-frame:
  - tx=1 and busy=0 from the next cycle; no data_end.
  - A new send_start of 32'h0000_00FF afterwards transmits correctly.
- Loopback into a UART receiver model, 100 random words with random idle gaps → every word received equals the word sent.
